// File: rtl/fir_mac_sched_if.sv
// fir_mac_sched_if: handshake and datapath-control bundle of the FIR MAC sequencer.
// master = sequencer side, slave = environment (history RAM, MAC array, sink).
interface fir_mac_sched_if #(
    parameter int PH_W = 4,
    parameter int CH_W = 1
) ();
    logic            s_tvalid;
    logic            s_tready;
    logic            wr_en;
    logic [PH_W-1:0] wr_addr;
    logic [PH_W-1:0] hist_addr;
    logic [PH_W-1:0] coef_addr;
    logic [CH_W-1:0] ch_sel;
    logic            acc_clr;
    logic            acc_en;
    logic            result_ld;
    logic            m_tvalid;
    logic            m_tready;
    logic [CH_W-1:0] m_tchan;

    modport master (
        input  s_tvalid,
        input  m_tready,
        output s_tready,
        output wr_en,
        output wr_addr,
        output hist_addr,
        output coef_addr,
        output ch_sel,
        output acc_clr,
        output acc_en,
        output result_ld,
        output m_tvalid,
        output m_tchan
    );

    modport slave (
        output s_tvalid,
        output m_tready,
        input  s_tready,
        input  wr_en,
        input  wr_addr,
        input  hist_addr,
        input  coef_addr,
        input  ch_sel,
        input  acc_clr,
        input  acc_en,
        input  result_ld,
        input  m_tvalid,
        input  m_tchan
    );
endinterface

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: control sequencer for a time-multiplexed decimating polyphase FIR.
// Ports: clk, rst (sync, active high); bus (master): s_tvalid/s_tready input beat,
//   wr_en/wr_addr history write, hist_addr/coef_addr/ch_sel/acc_clr/acc_en MAC control,
//   result_ld output capture, m_tvalid/m_tready/m_tchan result stream.
module fir_mac_sched #(
    parameter int TAP_COUNT = 120,
    parameter int MACS      = 8,
    parameter int DECIM     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAC_LAT   = 3
) (
    input  logic            clk,
    input  logic            rst,
    fir_mac_sched_if.master bus
);
    localparam int NPH  = TAP_COUNT / MACS;
    localparam int PH_W = (NPH > 1) ? $clog2(NPH) : 1;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPH - 1);
    localparam logic [PH_W-1:0] PH_NPH  = PH_W'(NPH);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
    localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [WT_W-1:0] WT_ONE  = WT_W'(1);

    if (TAP_COUNT % MACS != 0) begin : g_bad_taps
        $fatal(1, "fir_mac_sched: TAP_COUNT must be a multiple of MACS");
    end
    if (DECIM != MACS) begin : g_bad_decim
        $fatal(1, "fir_mac_sched: DECIM must equal MACS");
    end
    if (CHANNELS < 1 || NPH < 1 || MAC_LAT < 0) begin : g_bad_dims
        $fatal(1, "fir_mac_sched: CHANNELS, NPH must be >= 1, MAC_LAT >= 0");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_LOAD,
        S_OUT
    } state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] wr_addr_q, wr_addr_d;
    logic [PH_W-1:0] newest_q, newest_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [PH_W-1:0] hist_q, hist_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [WT_W-1:0] wait_q, wait_d;

    logic s_tready;
    logic wr_en;
    logic acc_en;
    logic acc_clr;
    logic result_ld;
    logic m_tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            newest_q  <= '0;
            phase_q   <= '0;
            hist_q    <= '0;
            ch_q      <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            newest_q  <= newest_d;
            phase_q   <= phase_d;
            hist_q    <= hist_d;
            ch_q      <= ch_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        newest_d  = newest_q;
        phase_d   = phase_q;
        ch_d      = ch_q;
        wait_d    = wait_q;
        s_tready  = 1'b0;
        wr_en     = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        result_ld = 1'b0;
        m_tvalid  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                s_tready = 1'b1;
                if (bus.s_tvalid) begin
                    wr_en     = 1'b1;
                    newest_d  = wr_addr_q;
                    wr_addr_d = (wr_addr_q == PH_LAST) ? '0
                                                       : wr_addr_q + PH_ONE;
                    ch_d      = '0;
                    phase_d   = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_en  = 1'b1;
                acc_clr = (phase_q == '0);
                if (phase_q == PH_LAST) begin
                    wait_d  = '0;
                    state_d = (MAC_LAT == 0) ? S_LOAD : S_WAIT;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            S_WAIT: begin
                if (wait_q == WT_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    wait_d = wait_q + WT_ONE;
                end
            end
            S_LOAD: begin
                result_ld = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                m_tvalid = 1'b1;
                if (bus.m_tready) begin
                    if (ch_q == CH_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        ch_d    = ch_q + CH_ONE;
                        phase_d = '0;
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read address walks backwards through the circular history from the
        // newest block; on borrow wrap by NPH since NPH need not be 2^PH_W.
        // Registered one cycle ahead so hist_addr comes straight from a flop.
        if (newest_d >= phase_d) begin
            hist_d = newest_d - phase_d;
        end else begin
            hist_d = newest_d + PH_NPH - phase_d;
        end
    end

    // Reset forces every output low, including the IDLE-state s_tready.
    assign bus.s_tready  = s_tready & ~rst;
    assign bus.wr_en     = wr_en & ~rst;
    assign bus.wr_addr   = rst ? '0 : wr_addr_q;
    assign bus.hist_addr = rst ? '0 : hist_q;
    assign bus.coef_addr = rst ? '0 : phase_q;
    assign bus.ch_sel    = rst ? '0 : ch_q;
    assign bus.acc_clr   = acc_clr & ~rst;
    assign bus.acc_en    = acc_en & ~rst;
    assign bus.result_ld = result_ld & ~rst;
    assign bus.m_tvalid  = m_tvalid & ~rst;
    assign bus.m_tchan   = rst ? '0 : ch_q;
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: scoreboard bench for fir_mac_sched.
// A schedule model predicts per-cycle control; a monitor pops expected results.
module tb_fir_mac_sched;
    localparam int TAP_COUNT   = 120;
    localparam int MACS        = 8;
    localparam int DECIM       = 8;
    localparam int CHANNELS    = 2;
    localparam int MAC_LAT     = 3;
    localparam int NPH         = TAP_COUNT / MACS;
    localparam int PH_W        = 4;
    localparam int CH_W        = 1;
    localparam int OUT_OFS     = NPH + MAC_LAT + 1;
    localparam int BEAT_PERIOD = 1 + CHANNELS * (NPH + MAC_LAT + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mac_sched_if #(.PH_W(PH_W), .CH_W(CH_W)) bus ();

    fir_mac_sched #(
        .TAP_COUNT(TAP_COUNT),
        .MACS     (MACS),
        .DECIM    (DECIM),
        .CHANNELS (CHANNELS),
        .MAC_LAT  (MAC_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    // Reference schedule: an accepted beat occupies the array for CHANNELS
    // passes; each pass is NPH MAC cycles, then MAC_LAT, one load, then OUT.
    bit   m_busy     = 1'b0;
    int   m_ch       = 0;
    int   m_start    = 0;
    int   m_newest   = 0;
    int   m_wr       = 0;
    int   m_accepts  = 0;
    int   mk;
    int   exp_q[$];
    logic [19:0] outs;

    always @(negedge clk) begin
        if (rst) begin
            outs = {bus.s_tready, bus.wr_en, bus.wr_addr, bus.hist_addr,
                    bus.coef_addr, bus.ch_sel, bus.acc_clr, bus.acc_en,
                    bus.result_ld, bus.m_tvalid, bus.m_tchan};
            check("rst_outputs", int'(outs), 0);
            m_busy = 1'b0;
            m_wr   = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            check("s_tready", int'(bus.s_tready), 1);
            check("wr_en", int'(bus.wr_en), int'(bus.s_tvalid));
            check("wr_addr", int'(bus.wr_addr), m_wr);
            check("acc_en_idle", int'(bus.acc_en), 0);
            check("result_ld_idle", int'(bus.result_ld), 0);
            check("m_tvalid_idle", int'(bus.m_tvalid), 0);
            if (bus.s_tvalid) begin
                m_busy   = 1'b1;
                m_newest = m_wr;
                m_wr     = (m_wr + 1) % NPH;
                m_ch     = 0;
                m_start  = cyc + 1;
                m_accepts++;
                for (int c = 0; c < CHANNELS; c++) exp_q.push_back(c);
            end
        end else begin
            mk = cyc - m_start;
            check("s_tready_busy", int'(bus.s_tready), 0);
            check("wr_en_busy", int'(bus.wr_en), 0);
            check("acc_en", int'(bus.acc_en), int'(mk < NPH));
            if (mk < NPH) begin
                check("coef_addr", int'(bus.coef_addr), mk);
                check("hist_addr", int'(bus.hist_addr),
                      (m_newest - mk + NPH) % NPH);
                check("acc_clr", int'(bus.acc_clr), int'(mk == 0));
                check("ch_sel", int'(bus.ch_sel), m_ch);
            end
            check("result_ld", int'(bus.result_ld), int'(mk == NPH + MAC_LAT));
            check("m_tvalid", int'(bus.m_tvalid), int'(mk >= OUT_OFS));
            if (mk >= OUT_OFS) begin
                check("m_tchan_hold", int'(bus.m_tchan), m_ch);
                if (bus.m_tready) begin
                    if (m_ch == CHANNELS - 1) begin
                        m_busy = 1'b0;
                    end else begin
                        m_ch++;
                        m_start = cyc + 1;
                    end
                end
            end
        end
        cyc++;
    end

    // Result monitor and accept-rate checks, decoupled from the stimulus.
    bit ph6       = 1'b0;
    int mon_cyc   = 0;
    int last_acc  = -1;
    int res_since = 0;
    int exp_ch;

    always @(negedge clk) begin
        if (!rst && bus.m_tvalid && bus.m_tready) begin
            check("sb_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_ch = exp_q.pop_front();
                check("m_tchan", int'(bus.m_tchan), exp_ch);
            end
            res_since++;
        end
        if (ph6 && !rst && bus.wr_en) begin
            if (last_acc >= 0) begin
                check("accept_gap", mon_cyc - last_acc, BEAT_PERIOD);
                check("results_per_beat", res_since, CHANNELS);
            end
            last_acc  = mon_cyc;
            res_since = 0;
        end
        mon_cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_busy) return;
            step();
        end
        check("idle_timeout", int'(m_busy), 0);
    endtask

    task automatic wait_phase(input int ofs, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_busy && m_ch == 0 && (cyc - m_start) == ofs) return;
            step();
        end
        check("phase_timeout", cyc - m_start, ofs);
    endtask

    task automatic one_beat();
        bus.s_tvalid = 1'b1;
        step();
        bus.s_tvalid = 1'b0;
    endtask

    int target;

    initial begin
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single beat, sink always ready
        one_beat();
        wait_idle(100);
        step();

        // 16 back-to-back beats from a fresh reset: write slot wraps
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        bus.s_tvalid = 1'b1;
        target = m_accepts + 16;
        for (int i = 0; i < 16 * BEAT_PERIOD + 20; i++) begin
            if (m_accepts >= target) break;
            step();
        end
        check("burst_accepts", m_accepts, target);
        bus.s_tvalid = 1'b0;
        wait_idle(100);

        // backpressure on channel 0 result
        bus.m_tready = 1'b0;
        one_beat();
        wait_phase(OUT_OFS, 100);
        repeat (10) step();
        bus.m_tready = 1'b1;
        wait_idle(100);

        // reset in the middle of the MAC sweep
        one_beat();
        wait_phase(7, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        check("abort_flush", exp_q.size(), 0);

        // continuous input, continuous sink
        ph6 = 1'b1;
        bus.s_tvalid = 1'b1;
        repeat (500) step();
        bus.s_tvalid = 1'b0;
        wait_idle(100);
        ph6 = 1'b0;

        // random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            bus.s_tvalid = ($urandom_range(0, 3) == 0);
            bus.m_tready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b1;
        wait_idle(200);
        step();
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
